// File: rtl/fir_mc_pkg.sv
// Shared op codes, FSM states and index-width helper for the multi-channel FIR MAC engine.
package fir_mc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 3'd0,
        OP_WR_X    = 3'd1,
        OP_WR_COEF = 3'd2,
        OP_RUN     = 3'd3,
        OP_RD_Y    = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Width of an index into n entries; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Accumulator to output conversion: optional round-half-up right shift, then clamp to DATA_W.
module fir_round_sat #(
    parameter int ACC_W  = 40,
    parameter int DATA_W = 16,
    parameter int SHIFT  = 0
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] y,
    output logic              sat
);

    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;

    // One guard bit so adding the rounding constant cannot wrap.
    assign ext = $signed({acc[ACC_W-1], acc});

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
            logic signed [ACC_W:0] sum;
            assign sum = ext + HALF;
            assign rnd = sum >>> SHIFT;
        end else begin : g_pass
            assign rnd = ext;
        end
    endgenerate

    always_comb begin
        sat = 1'b0;
        y   = rnd[DATA_W-1:0];
        if (rnd > MAX_V) begin
            y   = MAX_V[DATA_W-1:0];
            sat = 1'b1;
        end else if (rnd < MIN_V) begin
            y   = MIN_V[DATA_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac_mc.sv
// Multi-channel sequential FIR: host loads taps/samples per channel, RUN filters one block
// with a single shared signed MAC (one product per clock), results read back via RD_Y.
//
// state | meaning
// IDLE  | waiting for host ops; RUN accepted only here
// MAC   | acc += h[k]*x[n-k] for current sample n, one tap per cycle
// WB    | write rounded/saturated acc to out[ch][n], advance n
// FIN   | block complete, done raised, back to IDLE
module fir_mac_mc
    import fir_mc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 8,
    parameter int SIG_LEN  = 64,
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 40,
    parameter int SHIFT    = 0,
    localparam int CH_W    = idx_w(CHANNELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [CH_W-1:0]   ch,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] y,
    output logic              y_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf
);

    localparam int N_W = idx_w(SIG_LEN);
    localparam int K_W = idx_w(TAPS);
    localparam int P_W = DATA_W + COEF_W;
    localparam logic [31:0]    SIG_LEN_U = SIG_LEN;
    localparam logic [31:0]    TAPS_U    = TAPS;
    localparam logic [N_W-1:0] N_LAST    = N_W'(SIG_LEN - 1);
    localparam logic [K_W-1:0] K_LAST    = K_W'(TAPS - 1);

    logic signed [COEF_W-1:0] coef_mem [CHANNELS][TAPS];
    logic signed [DATA_W-1:0] x_mem    [CHANNELS][SIG_LEN];
    logic        [DATA_W-1:0] y_mem    [CHANNELS][SIG_LEN];

    state_e state, state_next;

    logic [CH_W-1:0]         run_ch;
    logic [N_W-1:0]          n;
    logic [K_W-1:0]          k;
    logic signed [ACC_W-1:0] acc;

    logic ch_ok, x_addr_ok, coef_addr_ok;
    logic wr_x, wr_coef, run_ok, rd_ok, reject;

    logic signed [31:0]      tap_idx;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic [DATA_W-1:0]       rs_y;
    logic                    rs_sat;

    // Host op decode
    assign ch_ok        = 32'(ch) < CHANNELS;
    assign x_addr_ok    = addr < SIG_LEN_U;
    assign coef_addr_ok = addr < TAPS_U;

    assign wr_x    = (op == OP_WR_X)    && !busy && ch_ok && x_addr_ok;
    assign wr_coef = (op == OP_WR_COEF) && !busy && ch_ok && coef_addr_ok;
    assign run_ok  = (op == OP_RUN)     && (state == ST_IDLE) && ch_ok;
    assign rd_ok   = (op == OP_RD_Y)    && ch_ok && x_addr_ok;

    assign reject = ((op == OP_WR_X)    && !wr_x)    ||
                    ((op == OP_WR_COEF) && !wr_coef) ||
                    ((op == OP_RUN)     && !run_ok)  ||
                    ((op == OP_RD_Y)    && !rd_ok);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            ST_IDLE: if (run_ok) state_next = ST_MAC;
            ST_MAC: begin
                busy = 1'b1;
                if (k == K_LAST) state_next = ST_WB;
            end
            ST_WB: begin
                busy       = 1'b1;
                state_next = (n == N_LAST) ? ST_FIN : ST_MAC;
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Samples before the block start read as zero without any pad storage.
    assign tap_idx = $signed(32'(n)) - $signed(32'(k));

    always_comb begin
        prod = '0;
        if (tap_idx >= 0) prod = coef_mem[run_ch][k] * x_mem[run_ch][tap_idx[N_W-1:0]];
    end

    assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};

    fir_round_sat #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc(acc),
        .y  (rs_y),
        .sat(rs_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            run_ch  <= '0;
            n       <= '0;
            k       <= '0;
            acc     <= '0;
        end else begin
            y_valid <= 1'b0;
            err     <= reject;
            if (op == OP_RD_Y) begin
                y_valid <= 1'b1;
                y       <= rd_ok ? y_mem[ch][addr[N_W-1:0]] : '0;
            end
            if (run_ok) begin
                run_ch <= ch;
                done   <= 1'b0;
                ovf    <= 1'b0;
                n      <= '0;
                k      <= '0;
                acc    <= '0;
            end
            if (state == ST_MAC) begin
                acc <= acc + prod_ext;
                k   <= k + 1'b1;
            end
            if (state == ST_WB) begin
                acc <= '0;
                k   <= '0;
                n   <= n + 1'b1;
                if (rs_sat)      ovf  <= 1'b1;
                if (n == N_LAST) done <= 1'b1;
            end
        end
    end

    // Sample and output memories keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wr_x) x_mem[ch][addr[N_W-1:0]] <= wdata;
        if (state == ST_WB) y_mem[run_ch][n] <= rs_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int t = 0; t < TAPS; t++)
                    coef_mem[c][t] <= '0;
        end else if (wr_coef) begin
            coef_mem[ch][addr[K_W-1:0]] <= wdata[COEF_W-1:0];
        end
    end

endmodule

// File: tb/tb_fir_mac_mc.sv
// Bench for fir_mac_mc: two instances (SHIFT=0 and SHIFT=1) share stimulus and are checked
// against a plain-arithmetic convolution model.
module tb_fir_mac_mc;

    localparam int TAPS = 4;
    localparam int SL   = 8;
    localparam int CHN  = 2;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_WRX  = 3'd1;
    localparam logic [2:0] C_WRC  = 3'd2;
    localparam logic [2:0] C_RUN  = 3'd3;
    localparam logic [2:0] C_RDY  = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic [0:0]  ch;
    logic [31:0] addr;
    logic [15:0] wdata;

    logic [15:0] y0, y1;
    logic yv0, yv1, busy0, busy1, done0, done1, err0, err1, ovf0, ovf1;

    always #5 clk = ~clk;

    fir_mac_mc #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .SIG_LEN(SL), .CHANNELS(CHN),
                 .ACC_W(40), .SHIFT(0)) u_dut0 (
        .clk(clk), .reset(reset), .op(op), .ch(ch), .addr(addr), .wdata(wdata),
        .y(y0), .y_valid(yv0), .busy(busy0), .done(done0), .err(err0), .ovf(ovf0));

    fir_mac_mc #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .SIG_LEN(SL), .CHANNELS(CHN),
                 .ACC_W(40), .SHIFT(1)) u_dut1 (
        .clk(clk), .reset(reset), .op(op), .ch(ch), .addr(addr), .wdata(wdata),
        .y(y1), .y_valid(yv1), .busy(busy1), .done(done1), .err(err1), .ovf(ovf1));

    int vectors    = 0;
    int miscompares = 0;

    int h_m [CHN][TAPS];
    int x_m [CHN][SL];
    int y_m [2][CHN][SL];
    bit ovf_m [2];

    function automatic int rs(input longint acc, input int sh, output bit sat);
        longint r;
        r = acc;
        if (sh > 0) r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
        sat = 1'b0;
        if (r > 32767) begin r = 32767; sat = 1'b1; end
        else if (r < -32768) begin r = -32768; sat = 1'b1; end
        return int'(r);
    endfunction

    task automatic model_run(input int c);
        for (int s = 0; s < 2; s++) begin
            ovf_m[s] = 1'b0;
            for (int n = 0; n < SL; n++) begin
                longint acc;
                bit sat;
                acc = 0;
                for (int t = 0; t < TAPS; t++)
                    if (n - t >= 0) acc += longint'(h_m[c][t]) * longint'(x_m[c][n-t]);
                y_m[s][c][n] = rs(acc, s, sat);
                ovf_m[s] |= sat;
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input int c, input int a, input int v);
        op    = o;
        ch    = c[0:0];
        addr  = a;
        wdata = v[15:0];
        @(posedge clk);
        #1;
        op = C_NOP;
    endtask

    task automatic load_x(input int c, input int v);
        x_m[c][0] = v;
    endtask

    task automatic write_x(input int c, input int a, input int v);
        issue(C_WRX, c, a, v);
        x_m[c][a] = v;
    endtask

    task automatic write_h(input int c, input int a, input int v);
        issue(C_WRC, c, a, v);
        h_m[c][a] = v;
    endtask

    task automatic read_channel(input int c);
        for (int a = 0; a < SL; a++) begin
            logic [15:0] e0, e1;
            e0 = 16'(y_m[0][c][a]);
            e1 = 16'(y_m[1][c][a]);
            issue(C_RDY, c, a, 0);
            vectors++;
            if (yv0 !== 1'b1 || err0 !== 1'b0 || y0 !== e0) begin
                miscompares++;
                $display("FAIL rd_y_s0 ch%0d[%0d]: got y=%h v=%b e=%b, expected y=%h v=1 e=0",
                         c, a, y0, yv0, err0, e0);
            end
            vectors++;
            if (yv1 !== 1'b1 || err1 !== 1'b0 || y1 !== e1) begin
                miscompares++;
                $display("FAIL rd_y_s1 ch%0d[%0d]: got y=%h v=%b e=%b, expected y=%h v=1 e=0",
                         c, a, y1, yv1, err1, e1);
            end
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy0 === 1'b1 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_and_check(input int c);
        int cyc;
        model_run(c);
        issue(C_RUN, c, 0, 0);
        vectors++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || done0 !== 1'b0 || ovf0 !== 1'b0) begin
            miscompares++;
            $display("FAIL run_start ch%0d: got busy=%b/%b done=%b ovf=%b, expected busy=1/1 done=0 ovf=0",
                     c, busy0, busy1, done0, ovf0);
        end
        wait_idle(cyc);
        vectors++;
        if (cyc != SL * (TAPS + 1)) begin
            miscompares++;
            $display("FAIL busy_len ch%0d: got %0d cycles, expected %0d", c, cyc, SL * (TAPS + 1));
        end
        vectors++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL done ch%0d: got done=%b/%b busy1=%b, expected done=1/1 busy1=0",
                     c, done0, done1, busy1);
        end
        vectors++;
        if (ovf0 !== ovf_m[0] || ovf1 !== ovf_m[1]) begin
            miscompares++;
            $display("FAIL ovf ch%0d: got %b/%b, expected %b/%b", c, ovf0, ovf1, ovf_m[0], ovf_m[1]);
        end
        read_channel(c);
    endtask

    task automatic test_reset;
        vectors++;
        if (y0 !== 16'h0 || yv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
            err0 !== 1'b0 || ovf0 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got y=%h v=%b busy=%b done=%b err=%b ovf=%b, expected all 0",
                     y0, yv0, busy0, done0, err0, ovf0);
        end
        for (int c = 0; c < CHN; c++)
            for (int t = 0; t < TAPS; t++) h_m[c][t] = 0;
    endtask

    task automatic test_impulse;
        for (int t = 0; t < TAPS; t++) write_h(0, t, t + 1);
        for (int a = 0; a < SL; a++) write_x(0, a, (a == 0) ? 1 : 0);
        run_and_check(0);
    endtask

    task automatic test_two_channel;
        for (int t = 0; t < TAPS; t++) write_h(1, t, 1);
        for (int a = 0; a < SL; a++) write_x(1, a, -(a + 1));
        run_and_check(1);
        read_channel(0);
    endtask

    task automatic test_saturation;
        for (int t = 0; t < TAPS; t++) write_h(0, t, 32767);
        for (int a = 0; a < SL; a++) write_x(0, a, 32767);
        run_and_check(0);
        for (int a = 0; a < SL; a++) write_x(0, a, -32768);
        run_and_check(0);
    endtask

    task automatic test_shift;
        for (int t = 0; t < TAPS; t++) write_h(0, t, (t == 0) ? 3 : 0);
        for (int a = 0; a < SL; a++) write_x(0, a, (a % 2 == 0) ? 1 : -1);
        run_and_check(0);
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < CHN; c++) begin
                for (int t = 0; t < TAPS; t++)
                    write_h(c, t, (it == 3) ? int'($urandom_range(0, 65535)) - 32768
                                            : int'($urandom_range(0, 400)) - 200);
                for (int a = 0; a < SL; a++)
                    write_x(c, a, (it == 3) ? int'($urandom_range(0, 65535)) - 32768
                                            : int'($urandom_range(0, 600)) - 300);
            end
            run_and_check(it % 2);
            read_channel((it + 1) % 2);
        end
    endtask

    task automatic test_busy_errors;
        int cyc;
        for (int t = 0; t < TAPS; t++) write_h(0, t, t - 2);
        for (int a = 0; a < SL; a++) write_x(0, a, 10 * a + 3);
        model_run(0);
        issue(C_RUN, 0, 0, 0);
        issue(C_WRX, 0, 1, 16'h7777);
        vectors++;
        if (err0 !== 1'b1 || err1 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_wr_x: got err=%b/%b, expected 1/1", err0, err1);
        end
        issue(C_WRC, 0, 1, 16'h5555);
        vectors++;
        if (err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_wr_coef: got err=%b, expected 1", err0);
        end
        issue(C_RUN, 1, 0, 0);
        vectors++;
        if (err0 !== 1'b1 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_run: got err=%b busy=%b, expected err=1 busy=1", err0, busy0);
        end
        issue(C_RDY, 1, 2, 0);
        vectors++;
        if (err0 !== 1'b0 || yv0 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_rd_y: got err=%b v=%b, expected err=0 v=1", err0, yv0);
        end
        wait_idle(cyc);
        vectors++;
        if (done0 !== 1'b1 || cyc >= 1000) begin
            miscompares++;
            $display("FAIL busy_done: got done=%b after %0d cycles, expected done=1", done0, cyc);
        end
        read_channel(0);
        issue(C_RDY, 0, SL, 0);
        vectors++;
        if (y0 !== 16'h0 || yv0 !== 1'b1 || err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_oob: got y=%h v=%b err=%b, expected y=0000 v=1 err=1", y0, yv0, err0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (err0 !== 1'b0 || yv0 !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_width: got err=%b v=%b, expected 0/0", err0, yv0);
        end
        issue(C_WRX, 0, SL, 1);
        vectors++;
        if (err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_x_oob: got err=%b, expected 1", err0);
        end
        issue(C_WRC, 0, TAPS, 1);
        vectors++;
        if (err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_coef_oob: got err=%b, expected 1", err0);
        end
        run_and_check(0);
    endtask

    task automatic test_reset_mid_run;
        issue(C_RUN, 0, 0, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b/%b done=%b/%b, expected all 0",
                     busy0, busy1, done0, done1);
        end
        for (int c = 0; c < CHN; c++)
            for (int t = 0; t < TAPS; t++) h_m[c][t] = 0;
        run_and_check(0);
        for (int t = 0; t < TAPS; t++) write_h(0, t, 2 * t - 3);
        run_and_check(0);
    endtask

    initial begin
        reset = 1'b1;
        op    = C_NOP;
        ch    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset;
        test_impulse;
        test_two_channel;
        test_saturation;
        test_shift;
        test_random;
        test_busy_errors;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
